// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared BCD digit type, digit limits and a load-clamp helper used by the
// BCD scan counter and its digit-step sub-module.
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    // Non-decimal nibbles (A..F) are stored as 9.
    function automatic bcd_t bcd_clamp(input bcd_t d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_counter_scan_if.sv
// ----------------------------------------------------------------------------
// bcd_counter_scan_if
// Signal bundle for bcd_counter_scan.
//   en, up, load, load_val : count controls (driven by master)
//   count, carry           : BCD count value and wrap pulse
//   x, y, z, w             : BCD code of the scanned digit (x = bit 3)
//   digit_sel              : one-hot select of the scanned digit
// There is no handshake: every signal is a plain level sampled or updated
// on each rising clock edge.
// ----------------------------------------------------------------------------
interface bcd_counter_scan_if #(
    parameter int DIGITS = 4
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  carry;
    logic                  x;
    logic                  y;
    logic                  z;
    logic                  w;
    logic [DIGITS-1:0]     digit_sel;

    modport master (
        output en, up, load, load_val,
        input  count, carry, x, y, z, w, digit_sel
    );

    modport slave (
        input  en, up, load, load_val,
        output count, carry, x, y, z, w, digit_sel
    );
endinterface

// File: rtl/bcd_digit_step.sv
// ----------------------------------------------------------------------------
// bcd_digit_step
// Combinational single BCD digit step, chained once per digit.
//   i_digit : current digit (0..9)
//   i_up    : 1 = increment, 0 = decrement
//   i_cin   : step request (carry/borrow in); when low the digit passes through
//   o_digit : next digit
//   o_cout  : carry (9 -> 0) or borrow (0 -> 9) out
// ----------------------------------------------------------------------------
module bcd_digit_step
    import bcd_pkg::*;
(
    input  bcd_t i_digit,
    input  logic i_up,
    input  logic i_cin,
    output bcd_t o_digit,
    output logic o_cout
);

    always_comb begin
        o_digit = i_digit;
        o_cout  = 1'b0;
        if (i_cin) begin
            if (i_up) begin
                if (i_digit >= BCD_MAX) begin
                    o_digit = BCD_MIN;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit + 4'd1;
                end
            end else begin
                if (i_digit == BCD_MIN) begin
                    o_digit = BCD_MAX;
                    o_cout  = 1'b1;
                end else begin
                    o_digit = i_digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_scan.sv
// ----------------------------------------------------------------------------
// bcd_counter_scan
// Multi-digit BCD up/down counter with a time-multiplexed digit scan output
// feeding a downstream combinational BCD-to-7-segment decoder.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : bcd_counter_scan_if slave (en/up/load/load_val in;
//          count/carry/x/y/z/w/digit_sel out)
// Parameters: DIGITS (2..8), SCAN_DIV (cycles per scan slot, >= 2).
// Optional macro BCD_SCAN_BLANK_EN: leading-zero blanking of digits > 0.
// ----------------------------------------------------------------------------
module bcd_counter_scan
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1000
) (
    input logic               clk,
    input logic               rst,
    bcd_counter_scan_if.slave bus
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] r_count;
    logic                r_carry;
    logic [PW-1:0]       r_presc;
    logic [IW-1:0]       r_idx;
    logic [DIGITS-1:0]   r_sel;
    bcd_t                r_xyzw;

    logic [4*DIGITS-1:0] w_next;
    logic [4*DIGITS-1:0] w_load;
    logic [DIGITS:0]     w_chain;
    logic                w_presc_tc;
    bcd_t                w_scan_digit;
    logic [DIGITS-1:0]   w_scan_sel;
    logic                w_blank;

    // Digit 0 always steps; higher digits step on the carry/borrow chain.
    assign w_chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .i_digit (r_count[4*g +: 4]),
            .i_up    (bus.up),
            .i_cin   (w_chain[g]),
            .o_digit (w_next[4*g +: 4]),
            .o_cout  (w_chain[g+1])
        );
        assign w_load[4*g +: 4] = bcd_clamp(bus.load_val[4*g +: 4]);
    end

    // Count register: load has priority over enable; carry pulses only on
    // a wrap out of the top digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else if (bus.load) begin
            r_count <= w_load;
            r_carry <= 1'b0;
        end else if (bus.en) begin
            r_count <= w_next;
            r_carry <= w_chain[DIGITS];
        end else begin
            r_carry <= 1'b0;
        end
    end

    // Scan prescaler and digit index.
    assign w_presc_tc = (r_presc == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (w_presc_tc) begin
            r_presc <= '0;
            r_idx   <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Select the scanned digit and its one-hot common.
    always_comb begin
        w_scan_digit = BCD_MIN;
        w_scan_sel   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_scan_digit  = r_count[4*i +: 4];
                w_scan_sel[i] = 1'b1;
            end
        end
    end

`ifdef BCD_SCAN_BLANK_EN
    // w_zero_from[i] is set when digits i..DIGITS-1 are all zero.
    logic [DIGITS:0] w_zero_from;
    assign w_zero_from[DIGITS] = 1'b1;
    for (genvar g = 0; g < DIGITS; g++) begin : g_zero
        assign w_zero_from[g] = w_zero_from[g+1] & (r_count[4*g +: 4] == BCD_MIN);
    end

    // Digit 0 is never blanked.
    always_comb begin
        w_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == IW'(i) && w_zero_from[i]) begin
                w_blank = 1'b1;
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Registered scan outputs, refreshed every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel  <= DIGITS'(1);
            r_xyzw <= BCD_MIN;
        end else if (w_blank) begin
            r_sel  <= '0;
            r_xyzw <= BCD_MIN;
        end else begin
            r_sel  <= w_scan_sel;
            r_xyzw <= w_scan_digit;
        end
    end

    assign bus.count     = r_count;
    assign bus.carry     = r_carry;
    assign bus.digit_sel = r_sel;
    assign bus.x         = r_xyzw[3];
    assign bus.y         = r_xyzw[2];
    assign bus.z         = r_xyzw[1];
    assign bus.w         = r_xyzw[0];

endmodule

// File: tb/tb_bcd_counter_scan.sv
// ----------------------------------------------------------------------------
// tb_bcd_counter_scan
// Scoreboard bench for bcd_counter_scan (DIGITS=4, SCAN_DIV=4). The reference
// model keeps the count as a plain integer and derives the scanned digit from
// the number of clock edges since reset.
// ----------------------------------------------------------------------------
module tb_bcd_counter_scan;

    localparam int D  = 4;
    localparam int SD = 4;
    localparam int W  = 4 * D;
    localparam int EW = W + 1 + D + 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bcd_counter_scan_if #(.DIGITS(D)) bus ();

    bcd_counter_scan #(.DIGITS(D), .SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    int m_val = 0;   // model count as a decimal integer
    int m_n   = 0;   // clock edges since reset release

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'((v / pow10(i)) % 10);
        return r;
    endfunction

    function automatic int from_bcd_clamped(input logic [W-1:0] b);
        int r = 0;
        int n;
        for (int i = 0; i < D; i++) begin
            n = int'(b[4*i +: 4]);
            if (n > 9) n = 9;
            r = r + n * pow10(i);
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge: drives inputs, pushes the expected outputs
    // after the next rising edge, then waits for the following falling edge.
    task automatic step(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
        int idx;
        int dig;
        logic [D-1:0] sel;
        logic cy;
        bus.en = e;
        bus.up = u;
        bus.load = l;
        bus.load_val = lv;

        // Display reflects the count and slot as they stood before this edge.
        idx = (m_n / SD) % D;
        sel = D'(1) << idx;
        dig = (m_val / pow10(idx)) % 10;
`ifdef BCD_SCAN_BLANK_EN
        if (idx > 0 && m_val < pow10(idx)) begin
            sel = '0;
            dig = 0;
        end
`endif
        cy = 1'b0;
        if (l) begin
            m_val = from_bcd_clamped(lv);
        end else if (e) begin
            if (u) begin
                cy = (m_val == pow10(D) - 1);
                m_val = (m_val + 1) % pow10(D);
            end else begin
                cy = (m_val == 0);
                m_val = (m_val == 0) ? pow10(D) - 1 : m_val - 1;
            end
        end
        m_n++;
        exp_q.push_back({to_bcd(m_val), cy, sel, 4'(dig)});
        @(negedge clk);
    endtask

    task automatic hold(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.en = 1'b0;
        bus.up = 1'b0;
        bus.load = 1'b0;
        bus.load_val = '0;
        m_val = 0;
        m_n = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_count"}, 32'(bus.count), 32'h0);
        chk({nm, "_carry"}, 32'(bus.carry), 32'h0);
        chk({nm, "_sel"},   32'(bus.digit_sel), 32'h1);
        chk({nm, "_xyzw"},  32'({bus.x, bus.y, bus.z, bus.w}), 32'h0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count", 32'(bus.count), 32'(e[EW-1 -: W]));
            chk("carry", 32'(bus.carry), 32'(e[D+4]));
            chk("digit_sel", 32'(bus.digit_sel), 32'(e[D+3 -: D]));
            chk("xyzw", 32'({bus.x, bus.y, bus.z, bus.w}), 32'(e[3:0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] lv;
        logic [W-1:0] corner[4];
        corner[0] = 16'h9999;
        corner[1] = 16'h0000;
        corner[2] = 16'h9998;
        corner[3] = 16'h0001;

        @(negedge clk);
        do_reset();
        chk_reset_vals("reset");

        // Count up 12 steps.
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, '0);
        chk("up12_count", 32'(bus.count), 32'h0012);

        // Wrap up from 9999, then wrap down from 0000.
        step(1'b0, 1'b0, 1'b1, 16'h9999);
        chk("load9999_carry", 32'(bus.carry), 32'h0);
        step(1'b1, 1'b1, 1'b0, '0);
        chk("wrap_up_count", 32'(bus.count), 32'h0000);
        chk("wrap_up_carry", 32'(bus.carry), 32'h1);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("wrap_dn_count", 32'(bus.count), 32'h9999);
        chk("wrap_dn_carry", 32'(bus.carry), 32'h1);
        hold(1);
        chk("carry_drop", 32'(bus.carry), 32'h0);

        // Clamped load.
        step(1'b0, 1'b0, 1'b1, 16'h12AF);
        chk("clamp_count", 32'(bus.count), 32'h1299);

        // Scan sequence from a fresh reset with 4321 held.
        do_reset();
        step(1'b0, 1'b0, 1'b1, 16'h4321);
        hold(22);

        // Leading zeros (blanked or shown depending on the build).
        step(1'b0, 1'b0, 1'b1, 16'h0007);
        hold(18);

        // Randomized traffic with occasional corner loads.
        for (int i = 0; i < 400; i++) begin
            int r = int'($urandom_range(0, 15));
            if (r == 0) begin
                lv = W'($urandom);
                step(1'(($urandom_range(0, 1))), 1'($urandom_range(0, 1)), 1'b1, lv);
            end else if (r == 1) begin
                step(1'b0, 1'b0, 1'b1, corner[$urandom_range(0, 3)]);
            end else if (r < 13) begin
                step(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0);
            end else begin
                hold(int'($urandom_range(1, 6)));
            end
        end

        // Asynchronous reset mid-count and mid-slot.
        step(1'b0, 1'b0, 1'b1, 16'h5678);
        hold(6);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst = 1'b0;
        m_val = 0;
        m_n = 0;
        bus.load = 1'b0;
        chk_reset_vals("post_rst");
        hold(12);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
